// File: rtl/bec_seq_pkg.sv
// rtl/bec_seq_pkg.sv - shared types and constants for the BEC op sequencer
// Purpose: FSM state encoding, register map addresses and CTRL/STATUS bit
//          positions shared by bec_field_regfile and bec_op_sequencer.
// Ports:   none (package).
package bec_seq_pkg;

  // Values double as the STATUS[6:4] state field.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    GAP  = 3'd2,
    RUN  = 3'd3,
    CAPT = 3'd4
  } seq_state_e;

  localparam int CTRL_ADDR       = 56;
  localparam int STATUS_ADDR     = 57;
  localparam int WORDS_PER_FIELD = 6;

  localparam int CTRL_START_BIT   = 0;
  localparam int CTRL_IRQ_CLR_BIT = 1;

  localparam int STAT_BUSY_BIT      = 0;
  localparam int STAT_IRQ_BIT       = 1;
  localparam int STAT_ERR_EARLY_BIT = 2;
  localparam int STAT_ERR_TO_BIT    = 3;
  localparam int STAT_STATE_LSB     = 4;

endpackage

// File: rtl/bec_field_regfile.sv
// rtl/bec_field_regfile.sv - wide operand/key/result storage with 32-bit word access
// Purpose: holds NUM_OPERANDS operand slots, one key slot and one result slot,
//          each FIELD_W bits, addressed as slot*8 + word. Words 0..5 map bits
//          [32w+31:32w]; bits above FIELD_W are dropped on write and read 0.
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   wr_en_i            word write strobe (caller gates it while busy)
//   addr_i, wdata_i    word address and write data
//   res_we_i           load result slot from res_data_i
//   rdata_o            combinational read of the addressed word
//   operands_o, key_o, result_o   full-width slot contents
module bec_field_regfile
  import bec_seq_pkg::*;
#(
  parameter int NUM_OPERANDS = 4,
  parameter int FIELD_W      = 163,
  parameter int ADDR_W       = 6
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  wr_en_i,
  input  logic [ADDR_W-1:0]                     addr_i,
  input  logic [31:0]                           wdata_i,
  input  logic                                  res_we_i,
  input  logic [FIELD_W-1:0]                    res_data_i,
  output logic [31:0]                           rdata_o,
  output logic [NUM_OPERANDS-1:0][FIELD_W-1:0]  operands_o,
  output logic [FIELD_W-1:0]                    key_o,
  output logic [FIELD_W-1:0]                    result_o
);

  localparam int NSLOTS = NUM_OPERANDS + 2;
  localparam int SLOT_W = ADDR_W - 3;
  localparam int PAD_W  = WORDS_PER_FIELD * 32;

  logic [FIELD_W-1:0] slot_q [NSLOTS];
  logic [SLOT_W-1:0]  a_slot;
  logic [2:0]         a_word;
  logic               a_word_ok;

  assign a_slot    = addr_i[ADDR_W-1:3];
  assign a_word    = addr_i[2:0];
  assign a_word_ok = (a_word < 3'(WORDS_PER_FIELD));

  // Zero-padding to a whole number of words makes the partial top word fall
  // out naturally: excess write bits are truncated, excess read bits are 0.
  function automatic logic [FIELD_W-1:0] merge_word(input logic [FIELD_W-1:0] cur,
                                                    input logic [2:0] w,
                                                    input logic [31:0] d);
    logic [PAD_W-1:0] pad;
    pad = PAD_W'(cur);
    pad[int'(w)*32 +: 32] = d;
    return pad[FIELD_W-1:0];
  endfunction

  function automatic logic [31:0] read_word(input logic [FIELD_W-1:0] cur,
                                            input logic [2:0] w);
    logic [PAD_W-1:0] pad;
    pad = PAD_W'(cur);
    return pad[int'(w)*32 +: 32];
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < NSLOTS; s++) slot_q[s] <= '0;
    end else begin
      // Result slot is not host-writable; only the capture path loads it.
      for (int s = 0; s < NSLOTS - 1; s++) begin
        if (wr_en_i && a_word_ok && (a_slot == SLOT_W'(s)))
          slot_q[s] <= merge_word(slot_q[s], a_word, wdata_i);
      end
      if (res_we_i) slot_q[NSLOTS-1] <= res_data_i;
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int s = 0; s < NSLOTS; s++) begin
      if (a_word_ok && (a_slot == SLOT_W'(s))) rdata_o = read_word(slot_q[s], a_word);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_OPERANDS; i++) operands_o[i] = slot_q[i];
  end

  assign key_o    = slot_q[NUM_OPERANDS];
  assign result_o = slot_q[NUM_OPERANDS+1];

endmodule

// File: rtl/bec_op_sequencer.sv
// rtl/bec_op_sequencer.sv - operand/scalar sequencer for the sm_bec_v3 core
// Purpose: loads operands into the core over load_data/trigLoad, feeds the
//          scalar MSB-first on ki per next_key, captures the result on done
//          and raises a sticky irq. Optional watchdog: BEC_SEQ_WATCHDOG_EN.
// Ports:
//   wb_clk_i, wb_rst_i                 clock, asynchronous active-high reset
//   reg_we, reg_addr, reg_wdata        register write port
//   reg_rdata                          combinational register read
//   irq, busy                          completion interrupt, run in progress
//   core_enable, core_load_data, core_load_status, core_data_out, core_ki
//                                      drive to the core
//   core_trig_load, core_next_key, core_done, core_data_in
//                                      returns from the core
module bec_op_sequencer
  import bec_seq_pkg::*;
#(
  parameter int NUM_OPERANDS = 4,
  parameter int FIELD_W      = 163,
  parameter int ADDR_W       = 6,
  parameter int TIMEOUT_CYC  = 2**20
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               reg_we,
  input  logic [ADDR_W-1:0]  reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  output logic               irq,
  output logic               busy,
  output logic               core_enable,
  output logic               core_load_data,
  output logic [2:0]         core_load_status,
  output logic [FIELD_W-1:0] core_data_out,
  input  logic               core_trig_load,
  output logic               core_ki,
  input  logic               core_next_key,
  input  logic               core_done,
  input  logic [FIELD_W-1:0] core_data_in
);

  localparam int BIT_W = $clog2(FIELD_W);

  seq_state_e         state_q, state_d;
  logic [2:0]         slot_q, slot_d;
  logic [BIT_W-1:0]   bit_idx_q, bit_idx_d;
  logic               key_exh_q, key_exh_d;
  logic               irq_q, irq_d;
  logic               err_early_q, err_early_d;
  logic               err_to_q, err_to_d;
  logic               res_we;
  logic               timeout;

  logic               ctrl_wr, start_req, irq_clr;
  logic [31:0]        rf_rdata;
  logic [FIELD_W-1:0] key;
  logic [FIELD_W-1:0] op_sel;
  logic [FIELD_W-1:0] result_unused;
  logic [NUM_OPERANDS-1:0][FIELD_W-1:0] operands;

  assign busy      = (state_q != IDLE);
  assign irq       = irq_q;
  assign ctrl_wr   = reg_we && (reg_addr == ADDR_W'(CTRL_ADDR));
  assign start_req = ctrl_wr && reg_wdata[CTRL_START_BIT];
  assign irq_clr   = ctrl_wr && reg_wdata[CTRL_IRQ_CLR_BIT];

  bec_field_regfile #(
    .NUM_OPERANDS (NUM_OPERANDS),
    .FIELD_W      (FIELD_W),
    .ADDR_W       (ADDR_W)
  ) u_regfile (
    .clk_i      (wb_clk_i),
    .rst_i      (wb_rst_i),
    .wr_en_i    (reg_we && !busy),
    .addr_i     (reg_addr),
    .wdata_i    (reg_wdata),
    .res_we_i   (res_we),
    .res_data_i (core_data_in),
    .rdata_o    (rf_rdata),
    .operands_o (operands),
    .key_o      (key),
    .result_o   (result_unused)
  );

  always_comb begin
    op_sel = '0;
    for (int i = 0; i < NUM_OPERANDS; i++) begin
      if (slot_q == 3'(i)) op_sel = operands[i];
    end
  end

`ifdef BEC_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            wd_active, wd_clear;

  // Counts stalled cycles; any forward progress from the core restarts it.
  always_comb begin
    wd_active = (state_q == LOAD) || (state_q == GAP) || (state_q == RUN);
    wd_clear  = ((state_q == LOAD) && core_trig_load) ||
                ((state_q == RUN)  && core_next_key);
    wd_d      = '0;
    timeout   = 1'b0;
    if (wd_active && !wd_clear) begin
      if (wd_q == WD_W'(TIMEOUT_CYC - 1)) timeout = 1'b1;
      else                                wd_d    = wd_q + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) wd_q <= '0;
    else          wd_q <= wd_d;
  end
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d          = state_q;
    slot_d           = slot_q;
    bit_idx_d        = bit_idx_q;
    key_exh_d        = key_exh_q;
    irq_d            = irq_q;
    err_early_d      = err_early_q;
    err_to_d         = err_to_q;
    res_we           = 1'b0;
    core_enable      = 1'b0;
    core_load_data   = 1'b0;
    core_load_status = '0;
    core_data_out    = '0;
    core_ki          = 1'b0;

    // Applied first so a same-cycle clear+start from IDLE clears, then starts,
    // and a completion in CAPT overrides a simultaneous clear.
    if (irq_clr) irq_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_req) begin
          slot_d      = '0;
          bit_idx_d   = BIT_W'(FIELD_W - 1);
          key_exh_d   = 1'b0;
          err_early_d = 1'b0;
          err_to_d    = 1'b0;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        core_load_data   = 1'b1;
        core_load_status = slot_q;
        core_data_out    = op_sel;
        if (core_trig_load) begin
          if (slot_q == 3'(NUM_OPERANDS - 1)) begin
            state_d = RUN;
          end else begin
            slot_d  = slot_q + 3'd1;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        state_d = LOAD;
      end
      RUN: begin
        core_enable = 1'b1;
        core_ki     = !key_exh_q && key[bit_idx_q];
        if (core_done) begin
          // done wins over a coincident next_key: bit_idx is left alone
          state_d = CAPT;
          if (!key_exh_q) err_early_d = 1'b1;
        end else if (core_next_key) begin
          if (bit_idx_q != '0) bit_idx_d = bit_idx_q - 1'b1;
          else                 key_exh_d = 1'b1;
        end
      end
      CAPT: begin
        core_enable = 1'b1;
        res_we      = 1'b1;
        irq_d       = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      state_d  = IDLE;
      err_to_d = 1'b1;
      irq_d    = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      bit_idx_q   <= '0;
      key_exh_q   <= 1'b0;
      irq_q       <= 1'b0;
      err_early_q <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      bit_idx_q   <= bit_idx_d;
      key_exh_q   <= key_exh_d;
      irq_q       <= irq_d;
      err_early_q <= err_early_d;
      err_to_q    <= err_to_d;
    end
  end

  always_comb begin
    reg_rdata = rf_rdata;
    if (reg_addr == ADDR_W'(STATUS_ADDR)) begin
      reg_rdata                          = '0;
      reg_rdata[STAT_BUSY_BIT]           = busy;
      reg_rdata[STAT_IRQ_BIT]            = irq_q;
      reg_rdata[STAT_ERR_EARLY_BIT]      = err_early_q;
      reg_rdata[STAT_ERR_TO_BIT]         = err_to_q;
      reg_rdata[STAT_STATE_LSB +: 3]     = state_q;
    end else if (reg_addr == ADDR_W'(CTRL_ADDR)) begin
      reg_rdata = '0;
    end
  end

endmodule
